// File: rtl/period_meter_pkg.sv
// Shared state encoding and counter limit helper for the period meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVF     = 2'd2
    } state_t;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Signal-under-test input and measurement results of the period meter.
interface period_meter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             overflow;
    logic             locked;

    modport master (
        output en, sig_in,
        input  period, period_valid, overflow, locked
    );

    modport slave (
        input  en, sig_in,
        output period, period_valid, overflow, locked
    );
endinterface

// File: rtl/period_meter_rise_edge_det.sv
// Registers the input once and flags a low-to-high transition.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic sig_d;

    always_ff @(posedge clk) begin
        if (rst) sig_d <= 1'b0;
        else     sig_d <= d;
    end

    assign rise = d & ~sig_d;
endmodule

// File: rtl/period_meter.sv
// Counts clk cycles between rising edges of sig_in; reports period,
// overflow on a stalled signal, and lock when two periods agree.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    period_meter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] period_q, period_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic             valid_q, valid_n;
    logic             ovf_q, ovf_n;
    logic             lock_q, lock_n;
    logic             has_prev, has_prev_n;
    logic             rise;

    rise_edge_det u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            period_q <= '0;
            prev     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            lock_q   <= 1'b0;
            has_prev <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            period_q <= period_n;
            prev     <= prev_n;
            valid_q  <= valid_n;
            ovf_q    <= ovf_n;
            lock_q   <= lock_n;
            has_prev <= has_prev_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        period_n   = period_q;
        prev_n     = prev;
        valid_n    = 1'b0;
        ovf_n      = ovf_q;
        lock_n     = lock_q;
        has_prev_n = has_prev;
        if (!bus.en) begin
            state_n    = IDLE;
            cnt_n      = '0;
            ovf_n      = 1'b0;
            lock_n     = 1'b0;
            has_prev_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        cnt_n   = WIDTH'(1);
                        state_n = MEASURE;
                    end else begin
                        cnt_n = '0;
                    end
                end
                MEASURE: begin
                    // A rise on the saturating cycle still counts as a period
                    if (rise) begin
                        period_n   = cnt;
                        valid_n    = 1'b1;
                        cnt_n      = WIDTH'(1);
                        lock_n     = has_prev && (prev == cnt);
                        prev_n     = cnt;
                        has_prev_n = 1'b1;
                    end else if (cnt == MAX) begin
                        ovf_n   = 1'b1;
                        lock_n  = 1'b0;
                        state_n = OVF;
                    end else begin
                        cnt_n = cnt + WIDTH'(1);
                    end
                end
                OVF: begin
                    if (rise) begin
                        ovf_n      = 1'b0;
                        cnt_n      = WIDTH'(1);
                        has_prev_n = 1'b0;
                        state_n    = MEASURE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.locked       = lock_q;
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: edge-timestamp reference model,
// gap table, hand-written corner sequences and randomized stimulus.
module tb_period_meter;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: timestamps of rising edges rather than a counter
    int t = 0;
    bit m_sig_d, armed, m_ovf, has_hist, m_valid, m_locked;
    int last_t, hist, m_period;

    task automatic model_update(input bit r, input bit e, input bit s);
        bit rise;
        int gap;
        t++;
        rise = s & ~m_sig_d;
        m_sig_d = r ? 1'b0 : s;
        m_valid = 1'b0;
        if (r) begin
            armed = 0; m_ovf = 0; m_period = 0; m_locked = 0;
            has_hist = 0; hist = 0;
        end else if (!e) begin
            armed = 0; m_ovf = 0; m_locked = 0; has_hist = 0;
        end else if (rise) begin
            if (armed && !m_ovf) begin
                gap = t - last_t;
                m_period = gap;
                m_valid = 1;
                m_locked = has_hist && (hist == gap);
                hist = gap;
                has_hist = 1;
            end else if (m_ovf) begin
                m_ovf = 0;
                has_hist = 0;
            end
            armed = 1;
            last_t = t;
        end else if (armed && !m_ovf && (t - last_t) >= MAX) begin
            m_ovf = 1;
            m_locked = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)",
                     name, act, exp, t);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit s);
        rst = r;
        bus.en = e;
        bus.sig_in = s;
        @(posedge clk);
        model_update(r, e, s);
        #1;
        check("period", int'(bus.period), m_period);
        check("period_valid", int'(bus.period_valid), int'(m_valid));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("locked", int'(bus.locked), int'(m_locked));
    endtask

    // One rise followed by gap-1 low cycles
    task automatic pulse(input int gap);
        step(0, 1, 1);
        for (int i = 1; i < gap; i++) step(0, 1, 0);
    endtask

    typedef struct {
        int gap;
        bit valid;
        int period;
        bit locked;
    } vec_t;

    vec_t tbl[$];
    int   nvalid;

    initial begin
        bus.en = 1'b0;
        bus.sig_in = 1'b0;
        step(1, 0, 0);
        check("reset_period", int'(bus.period), 0);
        check("reset_valid", int'(bus.period_valid), 0);
        check("reset_ovf", int'(bus.overflow), 0);
        check("reset_locked", int'(bus.locked), 0);

        // div_2: first rise arms, then period 2 and lock from second valid
        for (int i = 0; i < 12; i++) step(0, 1, (i % 2) == 0);
        check("div2_period", int'(bus.period), 2);
        check("div2_locked", int'(bus.locked), 1);

        // div_4 from a fresh arm: 100 cycles
        step(0, 0, 0);
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 1, (i % 4) < 2);
            if (bus.period_valid) nvalid++;
        end
        check("div4_period", int'(bus.period), 4);
        check("div4_locked", int'(bus.locked), 1);
        check("div4_valid_in_range", int'(nvalid >= 23 && nvalid <= 25), 1);

        // Gap table: each entry closes with a rise, checked right after it
        tbl = '{
            '{5, 1, 5, 0}, '{5, 1, 5, 1}, '{7, 1, 7, 0}, '{7, 1, 7, 1},
            '{20, 0, 7, 0}, '{6, 1, 6, 0}, '{6, 1, 6, 1},
            '{15, 1, 15, 0}, '{15, 1, 15, 1}, '{16, 0, 15, 0},
            '{3, 1, 3, 0}
        };
        step(0, 0, 0);
        pulse(1);
        for (int k = 0; k < tbl.size(); k++) begin
            for (int i = 1; i < tbl[k].gap; i++) step(0, 1, 0);
            if (tbl[k].gap > MAX)
                check("tbl_ovf_before_rise", int'(bus.overflow), 1);
            step(0, 1, 1);
            check("tbl_valid", int'(bus.period_valid), int'(tbl[k].valid));
            check("tbl_period", int'(bus.period), tbl[k].period);
            check("tbl_locked", int'(bus.locked), int'(tbl[k].locked));
            check("tbl_ovf", int'(bus.overflow), 0);
        end

        // rst mid-period while measuring div_4
        step(0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, (i % 4) < 2);
        step(1, 1, 0);
        check("rst_mid_period", int'(bus.period), 0);
        check("rst_mid_locked", int'(bus.locked), 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0);
        step(0, 1, 1);
        check("rst_first_rise_arms", int'(bus.period_valid), 0);
        step(0, 1, 1); step(0, 1, 0); step(0, 1, 0);
        step(0, 1, 1);
        check("rst_second_valid", int'(bus.period_valid), 1);
        check("rst_second_period", int'(bus.period), 4);

        // en dropped for 3 cycles with sig_in high: no false rise
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        check("en_no_false_valid", int'(bus.period_valid), 0);
        check("en_period_held", int'(bus.period), 4);
        check("en_locked_clear", int'(bus.locked), 0);
        check("en_ovf_clear", int'(bus.overflow), 0);
        step(0, 1, 0); step(0, 1, 0);
        step(0, 1, 1);
        check("en_rise_arms_only", int'(bus.period_valid), 0);
        step(0, 1, 1); step(0, 1, 0); step(0, 1, 0);
        step(0, 1, 1);
        check("en_then_period", int'(bus.period), 4);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = (i / 200) % 3;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) != 0,
                 p == 0 ? $urandom_range(0, 1) == 1
                        : p == 1 ? $urandom_range(0, 5) == 0
                                 : $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
Measures the period, in clk cycles, of a single-bit periodic signal, such as the div_2 and div_4 outputs of the synchronous counter. It is the consuming end of the divider outputs: it reports each measured period with a one-cycle valid strobe. It flags overflow when the signal stalls, and asserts lock once two consecutive periods match. Used as a self-check and monitor beside the counter blocks.

Parameters:
WIDTH, 8, width of the period counter and period output; maximum measurable period is 2^WIDTH-1 cycles.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  measurement enable; low forces IDLE
sig_in  input  1  signal under measurement; synchronous to clk, no synchroniser
period  output  WIDTH  last measured period in cycles between rising edges of sig_in
period_valid  output  1  one-cycle pulse when period is updated
overflow  output  1  level; counter saturated before the next rising edge
locked  output  1  level; the last two valid periods were equal

Behaviour:
- Reset (rst=1 at a clk edge): sig_d=0, cnt=0, state=IDLE, period=0, period_valid=0, overflow=0, locked=0, prev_period=0. rst has priority over everything.
- sig_d samples sig_in every cycle, including when en=0.
- Rise detection is combinational: rise = sig_in & ~sig_d.
- States: IDLE, MEASURE, OVF.
- IDLE:
  - en=1 and rise: cnt<=1, go MEASURE. No valid pulse; this first edge only arms.
  - Otherwise: stay in IDLE, cnt<=0.
- MEASURE, en=1:
  - rise: period<=cnt, period_valid<=1, cnt<=1, stay in MEASURE.
    - If prev_period==cnt and a previous valid exists: locked<=1; else locked<=0.
    - prev_period<=cnt.
  - No rise and cnt==2^WIDTH-1: overflow<=1, locked<=0, go OVF.
  - No rise otherwise: cnt<=cnt+1.
- OVF, en=1:
  - cnt holds.
  - rise: overflow<=0, cnt<=1, go MEASURE. No valid pulse; the previous-valid flag is cleared, so lock needs two fresh periods.
- Simultaneous rise and cnt==max in MEASURE: the rise wins; period=2^WIDTH-1 is reported valid, with no overflow.
- Latency: period and period_valid are registered. They appear in the cycle after the clk edge at which the closing rise was sampled.
- Period semantics: for a signal with rising edges N cycles apart, period=N. div_2 gives 2; div_4 gives 4.
- period_valid is high for exactly one cycle per measured period and is never high for two consecutive cycles unless N=1 (impossible for a registered sig_in, so never).
- en=0 at any time:
  - Go IDLE; cnt<=0; period_valid<=0; overflow<=0; locked<=0; previous-valid flag cleared.
  - period and prev_period hold their values.
- rst mid-measurement discards the partial count; the next rise after rst only arms.
- period holds its value between valid pulses and across overflow.
- Arithmetic: cnt is unsigned WIDTH bits and never wraps (saturation goes to OVF).

Decomposition:
- Shared package/include period_meter_pkg: state encodings (IDLE=2'd0, MEASURE=2'd1, OVF=2'd2) and a CNT_MAX constant function of WIDTH.
- One sub-module is natural: rise_edge_det (clk, rst, d -> rise), holding sig_d. Everything else stays in period_meter.

Test Plan:
- div_2 of fourbit_syncCounter_extended into sig_in, en=1 after rst -> first rise arms. From the second rise on, period=2 with period_valid pulsing every 2 cycles; locked=1 from the second valid onward; overflow=0.
- div_4 into sig_in -> period=4, valid every 4 cycles, locked=1 after two valids; 100 cycles produce 24±1 valid pulses.
- WIDTH=4, sig_in high for 1 cycle every 20 cycles -> cnt saturates at 15, overflow=1, locked=0. The next rise clears overflow with no valid; period stays at its prior value.
- Rising edges spaced 5, 5, 7, 7 cycles -> periods 5, 5 (locked=1), 7 (locked=0), 7 (locked=1).
- rst=1 for one cycle mid-period while measuring div_4 -> all outputs 0 the next cycle. The first rise after rst gives no valid; the next gives period=4.
- en dropped for 3 cycles then restored while sig_in=1 -> no false rise. The next real rise arms only; locked and overflow are 0, and period retains 4.
